onehot_dispatcher: RTL and testbench
====================================

// Module: onehot_dispatcher
// PURPOSE
//  Binary-index-to-one-hot dispatch engine, the issuing counterpart of the one-hot->index encoder path.
//  Accepts lane indices over a valid/ready stream and buffers them in a DEPTH-entry FIFO.
//  Drives a held one-hot request to the addressed PE lane until that lane acknowledges.
//  Sits between the layer scheduler (index producer) and the PE array lane enables.
// PARAMETERS
//  RADIX  16             number of PE lanes (width of one-hot bus); any value >= 2
//  WIDTH  $clog2(RADIX)  width of binary lane index
//  DEPTH  4              index FIFO depth; power of 2, >= 2
// PORTS
//  clk        in   1            clock, all state on rising edge
//  rst_n      in   1            asynchronous active-low reset
//  in_valid   in   1            producer has an index on in_idx
//  in_ready   out  1            FIFO can accept (count != DEPTH)
//  in_idx     in   WIDTH        target lane index
//  lane_req   out  RADIX        one-hot request to lanes; all-zero when idle
//  lane_ack   in   RADIX        per-lane acknowledge of lane_req
//  cur_idx    out  WIDTH        binary index of the lane currently requested (0 when idle)
//  done       out  1            1-cycle pulse: issue completed (ack seen)
//  err_oor    out  1            1-cycle pulse: accepted in_idx >= RADIX, entry discarded
//  count      out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (async, rst_n=0): lane_req=0, cur_idx=0, done=0, err_oor=0, count=0, FSM=IDLE, FIFO pointers=0.
//   Reset mid-issue drops the in-flight request and all queued entries immediately; no done pulse.
//  Push: in_valid && in_ready at an edge writes in_idx to FIFO, count+1. in_ready = (count != DEPTH),
//   combinational from count only; a same-cycle pop does NOT raise in_ready (no pass-through when full).
//  Range check: if accepted in_idx >= RADIX (only possible for non-power-of-2 RADIX), no write,
//   count unchanged, err_oor=1 the following cycle.
//  FSM states: IDLE, ISSUE.
//   IDLE: if count>0, at the edge pop head, lane_req <= (1<<head), cur_idx <= head, -> ISSUE.
//   ISSUE: lane_req held stable. When lane_ack[cur_idx]=1 at an edge: done<=1 next cycle;
//    if count>0 pop next head and load lane_req/cur_idx (stay ISSUE, back-to-back, no bubble);
//    else lane_req<=0, cur_idx<=0, -> IDLE.
//  Acks on lanes other than cur_idx, and any ack in IDLE, are ignored.
//  Latency: index accepted at edge N with FIFO empty and FSM IDLE -> lane_req visible after edge N+1.
//  Throughput: 1 issue/cycle when target lane acks in the cycle lane_req is first seen.
//  Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH; FIFO order strictly preserved.
//  lane_req is always zero or exactly one-hot; is registered (no combinational path from inputs).
//  count = number of queued entries, excluding the in-flight issue.
// TESTING
//  1 Reset: rst_n=0 mid-ISSUE with lane_req=16'h0008, count=2 -> lane_req=0, count=0, in_ready=1 asynchronously.
//  2 Single: push idx 5 at edge N, ack lane 5 at N+2 -> lane_req=16'h0020 after N+1, done pulse after N+2, then idle.
//  3 Back-to-back: push 3,3,15, lane_ack tied 16'hFFFF -> lane_req 0x0008,0x0008,0x8000 on consecutive cycles, 3 done pulses.
//  4 Full/backpressure: hold ack low, push 1 + DEPTH more -> first issued, count=4, in_ready=0, 6th held; ack lane 1 -> in_ready=1 next cycle.
//  5 Wrong-lane ack: issue idx 7, ack lane 6 only for 5 cycles -> lane_req stays 0x0080, no done; ack lane 7 -> done.
//  6 RADIX=12: push idx 13 -> err_oor pulse, count unchanged, no lane_req; push idx 11 -> lane_req=12'h800.

Source files
------------

// File: rtl/onehot_dispatcher.sv
// onehot_dispatcher: queues binary lane indices and holds a one-hot request on the target lane until it acks
module onehot_dispatcher #(
   parameter int RADIX = 16,
   parameter int WIDTH = $clog2(RADIX),
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_idx,
   output logic [RADIX-1:0]       lane_req,
   input  logic [RADIX-1:0]       lane_ack,
   output logic [WIDTH-1:0]       cur_idx,
   output logic                   done,
   output logic                   err_oor,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [WIDTH:0] LIMIT = RADIX[WIDTH:0];
   localparam logic [PW:0] FULL = DEPTH[PW:0];
   localparam logic [RADIX-1:0] ONE = {{(RADIX-1){1'b0}}, 1'b1};
   typedef enum logic {IDLE, ISSUE} state_t;
   state_t state, state_d;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [WIDTH-1:0] head, idx_d;
   logic [RADIX-1:0] req_d;
   logic push, in_range, wr, ack_hit, pop;
   assign in_ready = count != FULL;
   assign push = in_valid && in_ready;
   assign in_range = {1'b0, in_idx} < LIMIT;
   assign wr = push && in_range;
   assign head = mem[rd_ptr];
   // next issue: pop when idle or when the current lane acks, otherwise hold or drop to idle
   always_comb begin
      ack_hit = (state == ISSUE) && lane_ack[cur_idx];
      pop = (count != '0) && (state == IDLE || ack_hit);
      state_d = pop ? ISSUE : (ack_hit ? IDLE : state);
      req_d = pop ? ONE << head : (ack_hit ? '0 : lane_req);
      idx_d = pop ? head : (ack_hit ? '0 : cur_idx);
   end
   // index storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= in_idx;
   end
   // FSM, pointers, occupancy and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         lane_req <= '0;
         cur_idx <= '0;
         done <= 1'b0;
         err_oor <= 1'b0;
         count <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state <= state_d;
         lane_req <= req_d;
         cur_idx <= idx_d;
         done <= ack_hit;
         err_oor <= push && !in_range;
         count <= count + (PW+1)'(wr) - (PW+1)'(pop);
         wr_ptr <= wr_ptr + PW'(wr);
         rd_ptr <= rd_ptr + PW'(pop);
      end
   end
endmodule

// File: tb/tb_onehot_dispatcher.sv
// tb_onehot_dispatcher: vector table, corner sequences and randomized run against a queue-based model
module tb_onehot_dispatcher;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic v = 1'b0, rdy, dn, err;
   logic [3:0] idx = '0, cur;
   logic [15:0] ack = '0, req;
   logic [2:0] cnt;
   logic v12 = 1'b0, rdy12, dn12, err12;
   logic [3:0] idx12 = '0, cur12;
   logic [11:0] ack12 = '0, req12;
   logic [2:0] cnt12;
   int n_cmp = 0, n_bad = 0;
   int q[$];
   bit busy = 0;
   int mcur = 0;
   bit mdone = 0;
   typedef struct {
      bit v;
      bit [3:0] idx;
      bit [15:0] ack;
      bit [15:0] req;
      int cnt;
      bit dn;
   } vec_t;
   vec_t tbl[10];

   always #5 clk = ~clk;

   onehot_dispatcher #(.RADIX(16), .DEPTH(4)) u16 (
      .clk(clk), .rst_n(rst_n), .in_valid(v), .in_ready(rdy), .in_idx(idx),
      .lane_req(req), .lane_ack(ack), .cur_idx(cur), .done(dn), .err_oor(err), .count(cnt));

   onehot_dispatcher #(.RADIX(12), .DEPTH(4)) u12 (
      .clk(clk), .rst_n(rst_n), .in_valid(v12), .in_ready(rdy12), .in_idx(idx12),
      .lane_req(req12), .lane_ack(ack12), .cur_idx(cur12), .done(dn12), .err_oor(err12), .count(cnt12));

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // advance the model by one edge using the inputs currently driven, then clock the DUT
   task automatic step();
      bit hit = busy && ack[mcur];
      bit acc = v && q.size() != 4;
      mdone = hit;
      if (q.size() > 0 && (!busy || hit)) begin
         mcur = q.pop_front();
         busy = 1;
      end else if (hit) begin
         busy = 0;
         mcur = 0;
      end
      if (acc) q.push_back(int'(idx));
      @(posedge clk);
      #1;
   endtask

   task automatic cmp_model(string tag);
      chk({tag, " req"}, 32'(req), busy ? 32'(1) << mcur : 32'd0);
      chk({tag, " cur"}, 32'(cur), busy ? 32'(mcur) : 32'd0);
      chk({tag, " done"}, 32'(dn), 32'(mdone));
      chk({tag, " count"}, 32'(cnt), 32'(q.size()));
      chk({tag, " ready"}, 32'(rdy), 32'(q.size() != 4));
      chk({tag, " err"}, 32'(err), 32'd0);
   endtask

   task automatic do_reset();
      v = 0; ack = '0; v12 = 0; ack12 = '0;
      rst_n = 0;
      @(posedge clk);
      #2;
      rst_n = 1;
      q.delete();
      busy = 0; mcur = 0; mdone = 0;
   endtask

   initial begin
      tbl[0] = '{1, 4'd5,  16'h0000, 16'h0000, 1, 0};
      tbl[1] = '{0, 4'd0,  16'h0000, 16'h0020, 0, 0};
      tbl[2] = '{0, 4'd0,  16'h0020, 16'h0000, 0, 1};
      tbl[3] = '{0, 4'd0,  16'h0000, 16'h0000, 0, 0};
      tbl[4] = '{1, 4'd3,  16'hFFFF, 16'h0000, 1, 0};
      tbl[5] = '{1, 4'd3,  16'hFFFF, 16'h0008, 1, 0};
      tbl[6] = '{1, 4'd15, 16'hFFFF, 16'h0008, 1, 1};
      tbl[7] = '{0, 4'd0,  16'hFFFF, 16'h8000, 0, 1};
      tbl[8] = '{0, 4'd0,  16'hFFFF, 16'h0000, 0, 1};
      tbl[9] = '{0, 4'd0,  16'h0000, 16'h0000, 0, 0};

      do_reset();
      chk("rst req", 32'(req), 0);
      chk("rst cur", 32'(cur), 0);
      chk("rst done", 32'(dn), 0);
      chk("rst err", 32'(err), 0);
      chk("rst count", 32'(cnt), 0);
      chk("rst ready", 32'(rdy), 1);

      for (int i = 0; i < 10; i++) begin
         v = tbl[i].v; idx = tbl[i].idx; ack = tbl[i].ack;
         step();
         chk($sformatf("tbl%0d req", i), 32'(req), 32'(tbl[i].req));
         chk($sformatf("tbl%0d count", i), 32'(cnt), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d done", i), 32'(dn), 32'(tbl[i].dn));
         chk($sformatf("tbl%0d ready", i), 32'(rdy), 32'(tbl[i].cnt != 4));
      end

      do_reset();
      v = 1; idx = 3; step();
      idx = 1; step();
      step();
      v = 0;
      chk("midrst pre req", 32'(req), 32'h0008);
      chk("midrst pre count", 32'(cnt), 2);
      #2 rst_n = 0;
      #1;
      chk("midrst req", 32'(req), 0);
      chk("midrst count", 32'(cnt), 0);
      chk("midrst ready", 32'(rdy), 1);
      chk("midrst cur", 32'(cur), 0);
      @(posedge clk);
      #1;
      chk("midrst done", 32'(dn), 0);
      rst_n = 1;
      q.delete(); busy = 0; mcur = 0; mdone = 0;

      do_reset();
      v = 1;
      foreach (tbl[i]) if (i < 5) begin
         idx = (i == 0) ? 4'd1 : 4'(2 * i);
         step();
      end
      chk("full count", 32'(cnt), 4);
      chk("full ready", 32'(rdy), 0);
      chk("full req", 32'(req), 32'h0002);
      idx = 9; step();
      chk("full held count", 32'(cnt), 4);
      chk("full held ready", 32'(rdy), 0);
      ack = 16'h0002; step();
      chk("full ack count", 32'(cnt), 3);
      chk("full ack ready", 32'(rdy), 1);
      chk("full ack done", 32'(dn), 1);
      chk("full ack req", 32'(req), 32'h0004);
      ack = '0; step();
      chk("full 6th count", 32'(cnt), 4);
      v = 0; ack = 16'hFFFF;
      for (int i = 0; i < 6; i++) begin
         step();
         cmp_model($sformatf("drain%0d", i));
      end
      chk("drain empty", 32'(req), 0);

      do_reset();
      v = 1; idx = 7; step();
      v = 0; step();
      chk("wrong pre req", 32'(req), 32'h0080);
      ack = 16'h0040;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("wrong%0d req", i), 32'(req), 32'h0080);
         chk($sformatf("wrong%0d done", i), 32'(dn), 0);
      end
      ack = 16'h0080; step();
      chk("right done", 32'(dn), 1);
      chk("right req", 32'(req), 0);
      ack = '0;

      do_reset();
      v12 = 1; idx12 = 13; step();
      chk("r12 err", 32'(err12), 1);
      chk("r12 err count", 32'(cnt12), 0);
      chk("r12 err req", 32'(req12), 0);
      idx12 = 11; step();
      chk("r12 err clear", 32'(err12), 0);
      chk("r12 count", 32'(cnt12), 1);
      v12 = 0; step();
      chk("r12 req", 32'(req12), 32'h800);
      chk("r12 cur", 32'(cur12), 11);
      chk("r12 count0", 32'(cnt12), 0);

      do_reset();
      for (int i = 0; i < 600; i++) begin
         v = $urandom_range(0, 3) != 0;
         idx = 4'($urandom);
         ack = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom) & 16'($urandom) & 16'($urandom);
         step();
         cmp_model($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
